// File: rtl/iter_shifter.sv
// Multi-cycle shift/rotate unit: moves the operand up to STEP bits per cycle
// between a valid/ready request and a valid/ready response.
module iter_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_op,
    input  logic [CW-1:0]    in_cnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [CW-1:0] STEP_C  = CW'(STEP);
    localparam logic [CW:0]   WIDTH_C = (CW+1)'(WIDTH);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     work_q, shifted;
    logic [2*WIDTH-1:0]   sra;
    logic [2:0]           op_q;
    logic [CW-1:0]        rem_q, k;
    logic                 fill_q;
    logic                 accept, finish, bad_op;

    // Per-cycle shifter: only ever moves by k <= STEP positions.
    always_comb begin
        k   = (rem_q < STEP_C) ? rem_q : STEP_C;
        sra = {{WIDTH{fill_q}}, work_q} >> k;
        case (op_q)
            3'd0, 3'd2: shifted = work_q << k;
            3'd1:       shifted = work_q >> k;
            3'd3:       shifted = sra[WIDTH-1:0];
            3'd4:       shifted = (work_q << k) | (work_q >> (WIDTH_C - {1'b0, k}));
            3'd5:       shifted = (work_q >> k) | (work_q << (WIDTH_C - {1'b0, k}));
            default:    shifted = work_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        bad_op  = in_op[2] & in_op[1];
        case (state_q)
            IDLE: if (in_valid) begin
                accept  = 1'b1;
                state_d = (bad_op || in_cnt == '0) ? DONE : SHIFT;
            end
            SHIFT: if (rem_q == k) begin
                finish  = 1'b1;
                state_d = DONE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            work_q   <= '0;
            op_q     <= '0;
            rem_q    <= '0;
            fill_q   <= 1'b0;
            out_data <= '0;
            out_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                work_q <= in_data;
                op_q   <= in_op;
                fill_q <= in_data[WIDTH-1];
                rem_q  <= (state_d == SHIFT) ? in_cnt : '0;
                // Trivial requests skip SHIFT and publish the operand directly.
                if (state_d == DONE) begin
                    out_data <= in_data;
                    out_err  <= bad_op;
                end
            end
            if (state_q == SHIFT) begin
                work_q <= shifted;
                rem_q  <= rem_q - k;
                if (finish) begin
                    out_data <= shifted;
                    out_err  <= 1'b0;
                end
            end
        end
    end

    assign in_ready  = rst_n & (state_q == IDLE);
    assign out_valid = (state_q == DONE);

endmodule

// File: tb/tb_iter_shifter.sv
// Randomized scoreboard bench for iter_shifter, run at STEP=1 and STEP=4.
module tb_iter_shifter;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    bit done [2];

    typedef struct {
        logic [W-1:0] data;
        logic         err;
        int           lat;
        int           acc;
    } exp_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result straight from the op definitions; bit W is the error flag.
    function automatic logic [W:0] model(input logic [W-1:0] d, input logic [2:0] op, input int c);
        case (op)
            3'd0, 3'd2: return {1'b0, d << c};
            3'd1:       return {1'b0, d >> c};
            3'd3:       return {1'b0, W'($signed(d) >>> c)};
            3'd4:       return {1'b0, (d << c) | (d >> (W - c))};
            3'd5:       return {1'b0, (d >> c) | (d << (W - c))};
            default:    return {1'b1, d};
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] op, input int c, input int step);
        if (op >= 3'd6 || c == 0) return 1;
        return 1 + (c + step - 1) / step;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int ST = (g == 0) ? 1 : 4;

        logic         rst_n, in_valid, in_ready, out_valid, out_err;
        logic         out_ready = 1'b0;
        logic [W-1:0] in_data, out_data;
        logic [2:0]   in_op;
        logic [4:0]   in_cnt;

        exp_t         q[$];
        exp_t         e;
        bit           bp = 1'b0;
        bit           holding = 1'b0;
        bit           stalled = 1'b0;
        bit           chk_idle = 1'b0;
        int           hold_n = 0;
        int           rise = 0;
        logic [W-1:0] hd;
        logic         he;

        iter_shifter #(.WIDTH(W), .STEP(ST)) dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(in_valid), .in_ready(in_ready),
            .in_data(in_data), .in_op(in_op), .in_cnt(in_cnt),
            .out_valid(out_valid), .out_ready(out_ready),
            .out_data(out_data), .out_err(out_err)
        );

        task automatic issue(input logic [W-1:0] d, input logic [2:0] op,
                             input logic [4:0] c, input bit bpx);
            exp_t       x;
            logic [W:0] m;
            int         n = 0;
            @(negedge clk);
            while (!in_ready && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (!in_ready) begin
                chk("issue_timeout", in_ready, 1);
                return;
            end
            in_valid = 1'b1;
            in_data  = d;
            in_op    = op;
            in_cnt   = c;
            bp       = bpx;
            m        = model(d, op, int'(c));
            x.data   = m[W-1:0];
            x.err    = m[W];
            x.lat    = lat_of(op, int'(c), ST);
            x.acc    = cyc;
            q.push_back(x);
            @(negedge clk);
            // Garbage on the request bus mid-operation must be ignored.
            in_valid = 1'b0;
            in_data  = $urandom;
            in_op    = 3'($urandom);
            in_cnt   = 5'($urandom);
        endtask

        initial begin
            in_valid = 1'b0;
            in_data  = '0;
            in_op    = '0;
            in_cnt   = '0;
            rst_n    = 1'b1;
            #1 rst_n = 1'b0;
            repeat (3) @(negedge clk);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_err", out_err, 0);
            rst_n = 1'b1;
            @(negedge clk);
            chk("idle_in_ready", in_ready, 1);

            issue(32'h0000_00FF, 3'd0, 5'd4, 1'b0);
            issue(32'h8000_0000, 3'd3, 5'd31, 1'b0);
            issue(32'h8000_0001, 3'd4, 5'd1, 1'b0);
            issue(32'h0000_0001, 3'd5, 5'd4, 1'b0);
            issue(32'hDEAD_BEEF, 3'd1, 5'd0, 1'b0);
            issue(32'h1234_5678, 3'd6, 5'd9, 1'b0);
            issue(32'hCAFE_F00D, 3'd7, 5'd0, 1'b0);
            issue(32'hF0F0_1234, 3'd3, 5'd7, 1'b1);

            // Reset mid-SHIFT: the in-flight op must vanish without a trace.
            issue($urandom, 3'd1, 5'd20, 1'b0);
            repeat (3) @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            chk("midrst_out_valid", out_valid, 0);
            chk("midrst_out_data", out_data, 0);
            chk("midrst_in_ready", in_ready, 0);
            q.delete();
            @(negedge clk);
            #2 rst_n = 1'b1;
            @(negedge clk);
            chk("postrst_in_ready", in_ready, 1);
            repeat (40) @(negedge clk);

            for (int i = 0; i < 120; i++) begin
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                issue($urandom, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                      ($urandom_range(0, 15) == 0));
            end

            for (int n = 0; n < 2000 && q.size() > 0; n++) @(negedge clk);
            chk("drain", q.size(), 0);
            done[g] = 1'b1;
        end

        always @(negedge clk) begin
            if (rst_n) begin
                chk("ready_valid_excl", in_ready & out_valid, 0);
                if (chk_idle) begin
                    chk("idle_after_hs", {out_valid, in_ready}, 2'b01);
                    chk_idle = 1'b0;
                end
                if (out_valid) begin
                    if (!holding) begin
                        holding = 1'b1;
                        hd      = out_data;
                        he      = out_err;
                        rise    = cyc;
                        stalled = bp;
                        hold_n  = bp ? 10 : $urandom_range(0, 2);
                        bp      = 1'b0;
                        if (q.size() == 0) chk("stale_result", out_valid, 0);
                    end else begin
                        chk("hold_data", out_data, hd);
                        chk("hold_err", out_err, he);
                        if (stalled) chk("bp_in_ready", in_ready, 0);
                    end
                    if (hold_n == 0 && q.size() > 0) begin
                        e = q.pop_front();
                        chk("out_data", out_data, e.data);
                        chk("out_err", out_err, e.err);
                        chk("latency", rise - e.acc, e.lat);
                        out_ready = 1'b1;
                        holding   = 1'b0;
                        chk_idle  = 1'b1;
                    end else begin
                        out_ready = 1'b0;
                        if (hold_n > 0) hold_n--;
                    end
                end else begin
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    initial begin
        for (int n = 0; n < 80000 && !(done[0] && done[1]); n++) @(posedge clk);
        if (!(done[0] && done[1])) chk("global_timeout", {done[0], done[1]}, 2'b11);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
